multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multicycle sequencer for the LEGv8 datapath. It fetches an instruction over a ready-based handshake and latches it into IR. It then steps the shared datapath (register file, ALU, immediate sign-extension, data memory, PC) through FETCH/DECODE/EXEC/MEM/WB, and drives the immediate format select consumed by the sign-extension stage.

## Interface
- No parameters.
- CLK  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- IMemData  in  32  instruction word, valid when IMemReady=1
- IMemReady  in  1  instruction memory response strobe
- DMemReady  in  1  data memory completion strobe
- Zero  in  1  ALU zero flag (CBZ test operand == 0)
- IMemReq  out  1  instruction fetch request
- IR  out  32  latched instruction register
- ImmSel  out  2  immediate format: 00 none, 01 B (imm26), 10 D (imm9), 11 CB (imm19)
- ALUOp  out  2  00 add, 01 pass B, 10 R-type funct
- ALUSrcImm  out  1  ALU B operand = sign-extended immediate
- DMemReq  out  1  data memory request
- DMemWrite  out  1  data memory write (valid with DMemReq)
- RegWrite  out  1  register file write enable
- MemToReg  out  1  write-back source = data memory
- PCWrite  out  1  PC update strobe
- PCSrc  out  1  0 = PC+4, 1 = PC + (imm<<2), relative to the current instruction address
- Illegal  out  1  unsupported opcode trapped
- State  out  3  current state, for debug

## Operation
- Decode classes from IR:
  - B: [31:26]=000101.
  - LDUR: [31:21]=11111000010.
  - STUR: [31:21]=11111000000.
  - CBZ: [31:24]=10110100.
  - R-type [31:21]: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - Anything else is illegal.
- ImmSel is combinational from IR in every state except FETCH (00 in FETCH): B→01, LDUR/STUR→10, CBZ→11, else 00.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- FETCH:
  - IMemReq=1.
  - On IMemReady: IR←IMemData, go to DECODE. Otherwise stay.
- DECODE: one cycle, all strobes 0. Illegal→TRAP, else→EXEC.
- EXEC:
  - B: PCWrite=1, PCSrc=1 → FETCH.
  - CBZ: ALUOp=01, PCWrite=1, PCSrc=Zero → FETCH.
  - LDUR/STUR: ALUOp=00, ALUSrcImm=1 → MEM.
  - R-type: ALUOp=10 → WB.
- MEM:
  - ALUOp=00, ALUSrcImm=1 and DMemReq=1 held until DMemReady. DMemWrite=1 for STUR.
  - On DMemReady: STUR asserts PCWrite=1, PCSrc=0 → FETCH. LDUR → WB.
- WB:
  - RegWrite=1, PCWrite=1, PCSrc=0 → FETCH.
  - MemToReg=1 for LDUR, 0 for R-type. ALUOp=10 held for R-type.
- TRAP:
  - Illegal=1, all other strobes 0, IMemReq=0.
  - Held until Reset.
- Unlisted outputs are 0 in each state.

## Timing
- Reset value: State=FETCH, IR=0, Illegal=0. While Reset=1 every output strobe is forced to 0 combinationally.
- First IMemReq=1 occurs in the first cycle after Reset deasserts.
- All state-machine outputs are Moore outputs of state+IR, except the following combinational dependencies:
  - PCSrc in CBZ EXEC depends on Zero.
  - MEM-exit strobes (PCWrite for STUR) qualify on DMemReady in the same cycle.
- Same-cycle ready is legal: FETCH and MEM each occupy a minimum of 1 cycle.
- Minimum CPI: B=3, CBZ=3, R-type=4, STUR=4, LDUR=5. Each cycle without IMemReady/DMemReady adds one cycle.
- PCWrite pulses exactly once per retired instruction, in its last cycle. RegWrite pulses at most once.
- IMemReady/DMemReady are ignored outside FETCH/MEM respectively.
- Reset mid-operation (e.g. during a MEM wait): requests drop immediately, no write strobe fires, and the sequencer restarts at FETCH.

## Test plan
- Reset, then ADD 0x8B030041 with IMemReady=1 on the first FETCH cycle:
  - State sequence 0,1,2,4,0; IR=0x8B030041.
  - ALUOp=10 in EXEC and WB.
  - RegWrite=1, MemToReg=0, PCWrite=1, PCSrc=0 only in WB.
- LDUR 0xF8408041 with DMemReady delayed 3 cycles:
  - ImmSel=10 from DECODE on.
  - MEM lasts 4 cycles with DMemReq=1, DMemWrite=0.
  - Then WB with RegWrite=1, MemToReg=1; total 8 cycles.
- STUR 0xF8000041 with DMemReady=1 in the first MEM cycle:
  - DMemReq=DMemWrite=1 for 1 cycle.
  - PCWrite=1, PCSrc=0 in that cycle; RegWrite never asserted.
- CBZ 0xB4000045 run twice, Zero=1 then Zero=0:
  - ImmSel=11, ALUOp=01.
  - EXEC PCSrc=1 vs 0, PCWrite=1 both times; 3 cycles each.
- B 0x17FFFFFF: ImmSel=01, EXEC asserts PCWrite=1, PCSrc=1, then FETCH.
- Illegal 0x00000000 → TRAP (State=7), Illegal=1, IMemReq stays 0 for 20 cycles.
- Reset pulse during an LDUR MEM wait:
  - DMemReq drops to 0 within the reset cycle, no RegWrite.
  - IR=0, State=0, IMemReq=1 after release.

Source files
------------

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - LEGv8 multicycle sequencer: fetch handshake, IR latch, FETCH/DECODE/EXEC/MEM/WB control
module multicycle_controller (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] IMemData,
  input  logic        IMemReady,
  input  logic        DMemReady,
  input  logic        Zero,
  output logic        IMemReq,
  output logic [31:0] IR,
  output logic [1:0]  ImmSel,
  output logic [1:0]  ALUOp,
  output logic        ALUSrcImm,
  output logic        DMemReq,
  output logic        DMemWrite,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        Illegal,
  output logic [2:0]  State
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_ir;

  logic w_is_b, w_is_ldur, w_is_stur, w_is_cbz, w_is_rtype, w_is_illegal;
  logic [1:0] w_immsel;

  assign w_is_b     = (r_ir[31:26] == 6'b000101);
  assign w_is_ldur  = (r_ir[31:21] == 11'b11111000010);
  assign w_is_stur  = (r_ir[31:21] == 11'b11111000000);
  assign w_is_cbz   = (r_ir[31:24] == 8'b10110100);
  assign w_is_rtype = (r_ir[31:21] == 11'b10001011000) || (r_ir[31:21] == 11'b11001011000) ||
                      (r_ir[31:21] == 11'b10001010000) || (r_ir[31:21] == 11'b10101010000);
  assign w_is_illegal = ~(w_is_b | w_is_ldur | w_is_stur | w_is_cbz | w_is_rtype);

  always_comb begin
    w_immsel = 2'b00;
    if (w_is_b)                      w_immsel = 2'b01;
    else if (w_is_ldur || w_is_stur) w_immsel = 2'b10;
    else if (w_is_cbz)               w_immsel = 2'b11;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= S_FETCH;
      r_ir    <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && IMemReady) r_ir <= IMemData;
    end
  end

  logic       w_imemreq, w_srcimm, w_dmemreq, w_dmemwrite, w_regwrite;
  logic       w_memtoreg, w_pcwrite, w_pcsrc, w_illegal;
  logic [1:0] w_aluop;

  always_comb begin
    w_next      = r_state;
    w_imemreq   = 1'b0;
    w_aluop     = 2'b00;
    w_srcimm    = 1'b0;
    w_dmemreq   = 1'b0;
    w_dmemwrite = 1'b0;
    w_regwrite  = 1'b0;
    w_memtoreg  = 1'b0;
    w_pcwrite   = 1'b0;
    w_pcsrc     = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imemreq = 1'b1;
        if (IMemReady) w_next = S_DECODE;
      end
      S_DECODE: w_next = w_is_illegal ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (w_is_b) begin
          w_pcwrite = 1'b1;
          w_pcsrc   = 1'b1;
          w_next    = S_FETCH;
        end else if (w_is_cbz) begin
          w_aluop   = 2'b01;
          w_pcwrite = 1'b1;
          w_pcsrc   = Zero;
          w_next    = S_FETCH;
        end else if (w_is_ldur || w_is_stur) begin
          w_srcimm = 1'b1;
          w_next   = S_MEM;
        end else begin
          w_aluop = 2'b10;
          w_next  = S_WB;
        end
      end
      S_MEM: begin
        w_srcimm    = 1'b1;
        w_dmemreq   = 1'b1;
        w_dmemwrite = w_is_stur;
        // Store retires here; the PC strobe must qualify on the same-cycle completion
        if (DMemReady) begin
          w_pcwrite = w_is_stur;
          w_next    = w_is_stur ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        w_regwrite = 1'b1;
        w_pcwrite  = 1'b1;
        w_memtoreg = w_is_ldur;
        w_aluop    = w_is_rtype ? 2'b10 : 2'b00;
        w_next     = S_FETCH;
      end
      S_TRAP: w_illegal = 1'b1;
      default: w_next = S_FETCH;
    endcase
  end

  // Reset masks every strobe combinationally so nothing fires while it is held
  assign IMemReq   = w_imemreq & ~Reset;
  assign ALUOp     = Reset ? 2'b00 : w_aluop;
  assign ALUSrcImm = w_srcimm & ~Reset;
  assign DMemReq   = w_dmemreq & ~Reset;
  assign DMemWrite = w_dmemwrite & ~Reset;
  assign RegWrite  = w_regwrite & ~Reset;
  assign MemToReg  = w_memtoreg & ~Reset;
  assign PCWrite   = w_pcwrite & ~Reset;
  assign PCSrc     = w_pcsrc & ~Reset;
  assign Illegal   = w_illegal & ~Reset;
  assign ImmSel    = (Reset || r_state == S_FETCH) ? 2'b00 : w_immsel;
  assign IR        = r_ir;
  assign State     = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized scoreboard bench for multicycle_controller
module tb_multicycle_controller;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] IMemData;
  logic        IMemReady, DMemReady, Zero;
  logic        IMemReq, ALUSrcImm, DMemReq, DMemWrite, RegWrite, MemToReg, PCWrite, PCSrc, Illegal;
  logic [31:0] IR;
  logic [1:0]  ImmSel, ALUOp;
  logic [2:0]  State;

  multicycle_controller dut (
    .CLK(CLK), .Reset(Reset), .IMemData(IMemData), .IMemReady(IMemReady),
    .DMemReady(DMemReady), .Zero(Zero), .IMemReq(IMemReq), .IR(IR), .ImmSel(ImmSel),
    .ALUOp(ALUOp), .ALUSrcImm(ALUSrcImm), .DMemReq(DMemReq), .DMemWrite(DMemWrite),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .Illegal(Illegal), .State(State)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0]  st;
    logic [31:0] ir;
    logic [1:0]  imm;
    logic [1:0]  alu;
    logic srci, dreq, dwr, rw, m2r, pcw, pcs, ill, ireq;
  } rec_t;

  rec_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] model_ir = 32'd0;

  // Instruction classes: 0 B, 1 LDUR, 2 STUR, 3 CBZ, 4 R-type, 5 illegal
  function automatic int cls_of(input logic [31:0] w);
    logic [10:0] op;
    op = w[31:21];
    if (w[31:26] == 6'b000101) return 0;
    if (op == 11'h7C2) return 1;
    if (op == 11'h7C0) return 2;
    if (w[31:24] == 8'hB4) return 3;
    if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550) return 4;
    return 5;
  endfunction

  function automatic logic [1:0] imm_of(input logic [31:0] w);
    case (cls_of(w))
      0: return 2'b01;
      1, 2: return 2'b10;
      3: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic rec_t mk(input logic [2:0] st, input logic [1:0] alu,
                              input logic srci, dreq, dwr, rw, m2r, pcw, pcs, ill, ireq);
    rec_t r;
    r.st = st; r.ir = model_ir; r.imm = (st == 3'd0) ? 2'b00 : imm_of(model_ir);
    r.alu = alu; r.srci = srci; r.dreq = dreq; r.dwr = dwr; r.rw = rw; r.m2r = m2r;
    r.pcw = pcw; r.pcs = pcs; r.ill = ill; r.ireq = ireq;
    return r;
  endfunction

  always @(negedge CLK) begin
    rec_t e, a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.st = State; a.ir = IR; a.imm = ImmSel; a.alu = ALUOp; a.srci = ALUSrcImm;
      a.dreq = DMemReq; a.dwr = DMemWrite; a.rw = RegWrite; a.m2r = MemToReg;
      a.pcw = PCWrite; a.pcs = PCSrc; a.ill = Illegal; a.ireq = IMemReq;
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs cycle=%0d got st=%0d ir=%h imm=%b alu=%b srci=%b dreq=%b dwr=%b rw=%b m2r=%b pcw=%b pcs=%b ill=%b ireq=%b | exp st=%0d ir=%h imm=%b alu=%b srci=%b dreq=%b dwr=%b rw=%b m2r=%b pcw=%b pcs=%b ill=%b ireq=%b",
                 cyc, a.st, a.ir, a.imm, a.alu, a.srci, a.dreq, a.dwr, a.rw, a.m2r, a.pcw, a.pcs, a.ill, a.ireq,
                 e.st, e.ir, e.imm, e.alu, e.srci, e.dreq, e.dwr, e.rw, e.m2r, e.pcw, e.pcs, e.ill, e.ireq);
      end
    end
  end

  task automatic step(input rec_t e);
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic noise(input bit im, input bit dm);
    Zero = 1'($urandom);
    if (im) IMemReady = 1'($urandom);
    if (dm) DMemReady = 1'($urandom);
    IMemData = $urandom;
  endtask

  task automatic reset_cycle();
    Reset = 1'b1;
    noise(1, 1);
    model_ir = 32'd0;
    step(mk(3'd0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // abort >= 0 pulses Reset during that MEM wait cycle instead of finishing
  task automatic run_instr(input logic [31:0] instr, input int fw, input int mw,
                           input logic zv, input int abort);
    int c;
    Reset = 1'b0;
    for (int i = 0; i < fw; i++) begin
      noise(0, 1); IMemReady = 1'b0;
      step(mk(3'd0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    end
    noise(0, 1); IMemReady = 1'b1; IMemData = instr;
    step(mk(3'd0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    model_ir = instr;
    c = cls_of(instr);
    noise(1, 1);
    step(mk(3'd1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (c == 5) return;
    noise(1, 1);
    case (c)
      0: begin step(mk(3'd2, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 0)); return; end
      3: begin Zero = zv; step(mk(3'd2, 2'b01, 0, 0, 0, 0, 0, 1, zv, 0, 0)); return; end
      4: step(mk(3'd2, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      default: step(mk(3'd2, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    endcase
    if (c == 1 || c == 2) begin
      for (int k = 0; k < mw; k++) begin
        if (k == abort) begin
          reset_cycle();
          return;
        end
        noise(1, 0); DMemReady = 1'b0;
        step(mk(3'd3, 2'b00, 1, 1, c == 2, 0, 0, 0, 0, 0, 0));
      end
      noise(1, 0); DMemReady = 1'b1;
      if (c == 2) begin
        step(mk(3'd3, 2'b00, 1, 1, 1, 0, 0, 1, 0, 0, 0));
        return;
      end
      step(mk(3'd3, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    end
    noise(1, 1);
    step(mk(3'd4, (c == 4) ? 2'b10 : 2'b00, 0, 0, 0, 1, c == 1, 1, 0, 0, 0));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: return {6'b000101, r[25:0]};
      1: return {11'h7C2, r[20:0]};
      2: return {11'h7C0, r[20:0]};
      3: return {8'hB4, r[23:0]};
      default: begin
        case ($urandom_range(0, 3))
          0: return {11'h458, r[20:0]};
          1: return {11'h658, r[20:0]};
          2: return {11'h450, r[20:0]};
          default: return {11'h550, r[20:0]};
        endcase
      end
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1; IMemData = 32'd0; IMemReady = 1'b0; DMemReady = 1'b0; Zero = 1'b0;
    @(posedge CLK);
    #1;
    reset_cycle();
    reset_cycle();

    run_instr(32'h8B030041, 0, 0, 1'b0, -1);
    run_instr(32'hF8408041, 0, 3, 1'b0, -1);
    run_instr(32'hF8000041, 0, 0, 1'b0, -1);
    run_instr(32'hB4000045, 0, 0, 1'b1, -1);
    run_instr(32'hB4000045, 0, 0, 1'b0, -1);
    run_instr(32'h17FFFFFF, 0, 0, 1'b0, -1);
    run_instr(32'hF8408041, 1, 5, 1'b0, 2);
    run_instr(32'h8B030041, 2, 0, 1'b0, -1);

    for (int n = 0; n < 80; n++)
      run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), -1);

    run_instr(32'h00000000, 1, 0, 1'b0, -1);
    for (int t = 0; t < 20; t++) begin
      noise(1, 1);
      step(mk(3'd7, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    end
    reset_cycle();
    run_instr(32'hCB030041, 0, 0, 1'b0, -1);

    @(negedge CLK);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
